rank_cmd_arbiter: RTL and testbench
===================================

RANK_CMD_ARBITER -- requirements
Module: rank_cmd_arbiter

Interface
REQ-001 SHALL have parameter DQ_W, default 128, meaning write/read data width (= DQ_BITS*8).
REQ-002 SHALL have parameter TAG_DEPTH, default 4, meaning read-tag FIFO depth (power of two, 2..16).
REQ-003 SHALL have parameter GAP, default 2, meaning idle cycles inserted on a rank change.
REQ-004 SHALL have ports `clk  in  1` (single clock, all logic on rising edge) and `power_on_rst  in  1` (asynchronous, active-high reset).
REQ-005 SHALL have requester A ports:
- `a_req  in  1`: request.
- `a_rd  in  1`: 1 = read, 0 = write.
- `a_cmd  in  34`: command; bits [33:32] select the rank.
- `a_wdata  in  DQ_W`: write data.
- `a_gnt  out  1`: grant pulse.
- `a_rvalid  out  1`: read data valid for A.
REQ-006 SHALL have requester B ports `b_req`, `b_rd`, `b_cmd`, `b_wdata`, `b_gnt`, `b_rvalid`, identical to requester A.
REQ-007 SHALL have port `rdata  out  DQ_W`: shared read-return data.
REQ-008 SHALL have package-side ports:
- `pkg_command  out  34`, `pkg_valid  out  1`, `pkg_write_data  out  DQ_W`.
- `pkg_read_data  in  DQ_W`, `pkg_read_data_valid  in  1`, `pkg_ba_cmd_pm  in  4` (rank controller status).
REQ-009 SHALL have status ports `tag_err  out  1` (sticky) and `rd_outstanding  out  $clog2(TAG_DEPTH)+1` (count of in-flight reads).

Function
REQ-010 SHALL register all outputs.
REQ-011 SHALL use FSM states:
- IDLE: no eligible request.
- ISSUE: one command is driven for one cycle.
- GAP: counts GAP cycles after a rank change.
- WAIT: waits while `pkg_ba_cmd_pm != 0`.
REQ-012 SHALL treat a request as eligible when its req = 1 and it is either a write, or a read while the tag FIFO is not full.
REQ-013 SHALL arbitrate round-robin between eligible requesters; the pointer flips to the other requester after each grant; after reset A has priority.
REQ-014 SHALL, on issue, in the same cycle:
- pulse `pkg_valid` = 1 for exactly one cycle;
- drive `pkg_command` = winner cmd and `pkg_write_data` = winner wdata (0 for reads);
- pulse the winner's `gnt`.
REQ-015 SHALL have latency of 1 cycle from an eligible req sampled in IDLE to `pkg_valid`/`gnt`; requesters hold req/cmd/wdata stable until gnt.
REQ-016 SHALL issue at most one command every 2 cycles: ISSUE always returns to IDLE, GAP or WAIT.
REQ-017 SHALL enter WAIT instead of issuing while `pkg_ba_cmd_pm != 0`, and leave when it reads 0.
REQ-018 SHALL hold `pkg_command`, `pkg_write_data` and `pkg_valid` at 0 outside ISSUE.
REQ-019 SHALL push the requester ID into the tag FIFO on a read issue and pop it on `pkg_read_data_valid`.
REQ-020 SHALL, on a pop, register `pkg_read_data` to `rdata` and pulse `a_rvalid` or `b_rvalid` per the popped ID, 1 cycle after `pkg_read_data_valid`; `rdata` holds its value otherwise.
REQ-021 SHALL accept a simultaneous push and pop in one cycle; the count is unchanged.
REQ-022 SHALL, when the FIFO is full, block reads and still allow writes to issue.
REQ-023 SHALL, on `pkg_read_data_valid` with the FIFO empty, drop the data, raise no rvalid, and set `tag_err` = 1 until reset.
REQ-024 SHALL keep FIFO pointers at log2(TAG_DEPTH) bits, wrapping modulo TAG_DEPTH.

Reset
REQ-025 SHALL, while `power_on_rst` = 1 (asynchronous), force: state IDLE, all outputs 0, FIFO empty, `rd_outstanding` = 0, `tag_err` = 0, RR pointer = A, last rank = 0.
REQ-026 SHALL discard in-flight reads on reset mid-operation; no rvalid is generated for them.

Configuration
REQ-027 SHALL, when macro RANK_SWITCH_GAP_EN is defined, enter GAP for GAP cycles when an issued command's rank [33:32] differs from the previously issued rank; that command issues after the gap.
REQ-028 SHALL, when RANK_SWITCH_GAP_EN is undefined, omit the GAP state and rank tracking; rank changes issue with no penalty.

Verification
REQ-029 SHALL cover reset: `power_on_rst` pulse mid-read -> all outputs 0 next edge; a later `pkg_read_data_valid` sets `tag_err` = 1.
REQ-030 SHALL cover round-robin: A and B both request writes continuously -> gnt order A,B,A,B; `pkg_valid` every 2nd cycle.
REQ-031 SHALL cover read routing: A reads rank 1, then B reads rank 1; two `pkg_read_data_valid` with data 0x11..,0x22.. -> a_rvalid with 0x11.., then b_rvalid with 0x22...
REQ-032 SHALL cover FIFO full: 4 outstanding reads with A still requesting a read -> no gnt; a B write is granted; A is granted 2 cycles after one pop.
REQ-033 SHALL cover rank switch with the macro defined: rank 0 then rank 2 writes -> second `pkg_valid` GAP+2 = 4 cycles after the first; without the macro, 2 cycles.
REQ-034 SHALL cover busy: `pkg_ba_cmd_pm` = 4'b0010 for 5 cycles -> no `pkg_valid` in that window; the pending request issues 1 cycle after status returns to 0.

Source files
------------

// File: rtl/rank_cmd_arbiter_if.sv
// rank_cmd_arbiter_if
// Groups the requester, memory-package and status signals of
// rank_cmd_arbiter into one bundle.
//   slave  : the arbiter side (takes requests, drives the package command bus)
//   master : the environment side (requesters A/B plus the package model)
// Requester A/B : req, rd, cmd[33:0] (rank in [33:32]), wdata, gnt, rvalid
// Package       : pkg_command, pkg_valid, pkg_write_data, pkg_read_data,
//                 pkg_read_data_valid, pkg_ba_cmd_pm
// Status        : rdata, tag_err, rd_outstanding
interface rank_cmd_arbiter_if #(
  parameter int DQ_W      = 128,
  parameter int TAG_DEPTH = 4
);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  logic             a_req;
  logic             a_rd;
  logic [33:0]      a_cmd;
  logic [DQ_W-1:0]  a_wdata;
  logic             a_gnt;
  logic             a_rvalid;

  logic             b_req;
  logic             b_rd;
  logic [33:0]      b_cmd;
  logic [DQ_W-1:0]  b_wdata;
  logic             b_gnt;
  logic             b_rvalid;

  logic [DQ_W-1:0]  rdata;

  logic [33:0]      pkg_command;
  logic             pkg_valid;
  logic [DQ_W-1:0]  pkg_write_data;
  logic [DQ_W-1:0]  pkg_read_data;
  logic             pkg_read_data_valid;
  logic [3:0]       pkg_ba_cmd_pm;

  logic             tag_err;
  logic [CNT_W-1:0] rd_outstanding;

  modport slave (
    input  a_req, a_rd, a_cmd, a_wdata,
    input  b_req, b_rd, b_cmd, b_wdata,
    input  pkg_read_data, pkg_read_data_valid, pkg_ba_cmd_pm,
    output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata,
    output pkg_command, pkg_valid, pkg_write_data,
    output tag_err, rd_outstanding
  );

  modport master (
    output a_req, a_rd, a_cmd, a_wdata,
    output b_req, b_rd, b_cmd, b_wdata,
    output pkg_read_data, pkg_read_data_valid, pkg_ba_cmd_pm,
    input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata,
    input  pkg_command, pkg_valid, pkg_write_data,
    input  tag_err, rd_outstanding
  );
endinterface

// File: rtl/rank_cmd_arbiter.sv
// rank_cmd_arbiter
// Round-robin arbiter between two command requesters (A, B) feeding one
// memory-package command port. Reads push the requester ID into a tag FIFO;
// returned read data is routed back by popping that FIFO.
// Ports: clk, power_on_rst (async, active high), bus (rank_cmd_arbiter_if.slave).
// Optional feature: define RANK_SWITCH_GAP_EN to insert GAP idle cycles
// before a command whose rank differs from the previously issued one.
//
// state   | meaning
// IDLE    | no eligible request
// ISSUE   | one command driven on the package port for this cycle
// WAIT    | package busy (pkg_ba_cmd_pm != 0), issue held off
// GAP     | counting idle cycles after a rank change (RANK_SWITCH_GAP_EN only)
module rank_cmd_arbiter #(
  parameter int DQ_W      = 128,
  parameter int TAG_DEPTH = 4,
  parameter int GAP       = 2
) (
  input  logic              clk,
  input  logic              power_on_rst,
  rank_cmd_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;
`ifdef RANK_SWITCH_GAP_EN
  localparam int GCNT_W = (GAP > 1) ? $clog2(GAP) : 1;
`endif

  if (TAG_DEPTH < 2 || TAG_DEPTH > 16 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0 || GAP < 0)
  begin : g_bad_params
    $fatal(1, "rank_cmd_arbiter: TAG_DEPTH must be a power of two in 2..16, GAP >= 0");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
`ifdef RANK_SWITCH_GAP_EN
    , S_GAP = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;               // 1: B has priority
  logic [TAG_DEPTH-1:0] tag_mem_q, tag_mem_d; // 0 = A, 1 = B
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tag_err_q, tag_err_d;
  logic [DQ_W-1:0]  rdata_q, rdata_d;
  logic             a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [33:0]      pkg_command_q, pkg_command_d;
  logic [DQ_W-1:0]  pkg_wdata_q, pkg_wdata_d;
  logic             pkg_valid_q, pkg_valid_d;
  logic             a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
`ifdef RANK_SWITCH_GAP_EN
  logic [1:0]       last_rank_q, last_rank_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
`endif

  logic fifo_full, fifo_empty, a_elig, b_elig, any_elig, pick_b, busy;
  logic issue, try_issue, push, pop, win_rd;
  logic [33:0]     win_cmd;
  logic [DQ_W-1:0] win_wdata;

  assign fifo_full  = (cnt_q == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign a_elig     = bus.a_req & (~bus.a_rd | ~fifo_full);
  assign b_elig     = bus.b_req & (~bus.b_rd | ~fifo_full);
  assign any_elig   = a_elig | b_elig;
  assign pick_b     = b_elig & (~a_elig | rr_q);
  assign win_cmd    = pick_b ? bus.b_cmd   : bus.a_cmd;
  assign win_rd     = pick_b ? bus.b_rd    : bus.a_rd;
  assign win_wdata  = pick_b ? bus.b_wdata : bus.a_wdata;
  assign busy       = (bus.pkg_ba_cmd_pm != 4'd0);

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    pkg_valid_d   = 1'b0;
    pkg_command_d = '0;
    pkg_wdata_d   = '0;
    a_gnt_d       = 1'b0;
    b_gnt_d       = 1'b0;
    issue         = 1'b0;
    try_issue     = 1'b0;
`ifdef RANK_SWITCH_GAP_EN
    last_rank_d   = last_rank_q;
    gcnt_d        = gcnt_q;
`endif
    case (state_q)
      S_IDLE, S_WAIT: try_issue = 1'b1;
      S_ISSUE:        state_d   = S_IDLE;
`ifdef RANK_SWITCH_GAP_EN
      S_GAP: begin
        if (gcnt_q == '0) try_issue = 1'b1;
        else              gcnt_d    = gcnt_q - GCNT_W'(1);
      end
`endif
      default:        state_d   = S_IDLE;
    endcase

    // Arbitration is re-evaluated every time an issue is attempted, so a
    // command held off by WAIT or GAP goes out with current eligibility.
    if (try_issue) begin
      if (!any_elig) begin
        state_d = S_IDLE;
      end else if (busy) begin
        state_d = S_WAIT;
      end
`ifdef RANK_SWITCH_GAP_EN
      // Rank is recorded on entering GAP so the retry after the gap issues.
      else if (GAP > 0 && win_cmd[33:32] != last_rank_q) begin
        state_d     = S_GAP;
        gcnt_d      = GCNT_W'(GAP - 1);
        last_rank_d = win_cmd[33:32];
      end
`endif
      else begin
        issue         = 1'b1;
        state_d       = S_ISSUE;
        pkg_valid_d   = 1'b1;
        pkg_command_d = win_cmd;
        pkg_wdata_d   = win_rd ? '0 : win_wdata;
        a_gnt_d       = ~pick_b;
        b_gnt_d       = pick_b;
        rr_d          = ~pick_b;
`ifdef RANK_SWITCH_GAP_EN
        last_rank_d   = win_cmd[33:32];
`endif
      end
    end
  end

  assign push = issue & win_rd;
  assign pop  = bus.pkg_read_data_valid & ~fifo_empty;

  always_comb begin
    tag_mem_d = tag_mem_q;
    if (push) tag_mem_d[wr_ptr_q] = pick_b;
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    a_rvalid_d = pop & ~tag_mem_q[rd_ptr_q];
    b_rvalid_d = pop &  tag_mem_q[rd_ptr_q];
    rdata_d    = pop ? bus.pkg_read_data : rdata_q;
    // Returned data with no matching tag is dropped and flagged until reset.
    tag_err_d  = tag_err_q | (bus.pkg_read_data_valid & fifo_empty);
  end

  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      state_q       <= S_IDLE;
      rr_q          <= 1'b0;
      tag_mem_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      tag_err_q     <= 1'b0;
      rdata_q       <= '0;
      a_rvalid_q    <= 1'b0;
      b_rvalid_q    <= 1'b0;
      pkg_command_q <= '0;
      pkg_wdata_q   <= '0;
      pkg_valid_q   <= 1'b0;
      a_gnt_q       <= 1'b0;
      b_gnt_q       <= 1'b0;
`ifdef RANK_SWITCH_GAP_EN
      last_rank_q   <= 2'd0;
      gcnt_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      tag_mem_q     <= tag_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      tag_err_q     <= tag_err_d;
      rdata_q       <= rdata_d;
      a_rvalid_q    <= a_rvalid_d;
      b_rvalid_q    <= b_rvalid_d;
      pkg_command_q <= pkg_command_d;
      pkg_wdata_q   <= pkg_wdata_d;
      pkg_valid_q   <= pkg_valid_d;
      a_gnt_q       <= a_gnt_d;
      b_gnt_q       <= b_gnt_d;
`ifdef RANK_SWITCH_GAP_EN
      last_rank_q   <= last_rank_d;
      gcnt_q        <= gcnt_d;
`endif
    end
  end

  assign bus.a_gnt          = a_gnt_q;
  assign bus.b_gnt          = b_gnt_q;
  assign bus.a_rvalid       = a_rvalid_q;
  assign bus.b_rvalid       = b_rvalid_q;
  assign bus.rdata          = rdata_q;
  assign bus.pkg_command    = pkg_command_q;
  assign bus.pkg_valid      = pkg_valid_q;
  assign bus.pkg_write_data = pkg_wdata_q;
  assign bus.tag_err        = tag_err_q;
  assign bus.rd_outstanding = cnt_q;
endmodule

// File: tb/tb_rank_cmd_arbiter.sv
module tb_rank_cmd_arbiter;
  localparam int DQ_W      = 128;
  localparam int TAG_DEPTH = 4;
  localparam int GAP       = 2;
  localparam int CNT_W     = $clog2(TAG_DEPTH) + 1;
`ifdef RANK_SWITCH_GAP_EN
  localparam int EXP_SW = GAP + 2;
`else
  localparam int EXP_SW = 2;
`endif

  localparam logic [33:0]     CA = 34'h0_1234_5678;
  localparam logic [33:0]     CB = 34'h0_8765_4321;
  localparam logic [DQ_W-1:0] WA = 128'hAAAA_0001;
  localparam logic [DQ_W-1:0] WB = 128'hBBBB_0002;

  logic clk = 1'b0;
  logic power_on_rst;
  always #5 clk = ~clk;

  rank_cmd_arbiter_if #(.DQ_W(DQ_W), .TAG_DEPTH(TAG_DEPTH)) bus ();
  rank_cmd_arbiter #(.DQ_W(DQ_W), .TAG_DEPTH(TAG_DEPTH), .GAP(GAP)) dut (
    .clk(clk), .power_on_rst(power_on_rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.a_req = 0; bus.a_rd = 0; bus.a_cmd = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_rd = 0; bus.b_cmd = '0; bus.b_wdata = '0;
    bus.pkg_read_data = '0; bus.pkg_read_data_valid = 0; bus.pkg_ba_cmd_pm = '0;
  endtask

  task automatic do_reset();
    power_on_rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    power_on_rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_pkg_valid"}, bus.pkg_valid, 0);
    chk({name, "_pkg_command"}, bus.pkg_command, 0);
    chk({name, "_pkg_wdata"}, bus.pkg_write_data, 0);
    chk({name, "_gnts"}, {bus.a_gnt, bus.b_gnt}, 0);
    chk({name, "_rvalids"}, {bus.a_rvalid, bus.b_rvalid}, 0);
    chk({name, "_rdata"}, bus.rdata, 0);
    chk({name, "_tag_err"}, bus.tag_err, 0);
    chk({name, "_rd_outstanding"}, bus.rd_outstanding, 0);
  endtask

  task automatic wait_gnt(input bit is_b, input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = is_b ? bus.b_gnt : bus.a_gnt;
    end
    chk(name, seen, 1);
  endtask

  typedef struct {
    logic a_req, a_rd; logic [33:0] a_cmd; logic [DQ_W-1:0] a_wd;
    logic b_req, b_rd; logic [33:0] b_cmd; logic [DQ_W-1:0] b_wd;
    logic e_agnt, e_bgnt; logic [33:0] e_cmd; logic [DQ_W-1:0] e_wd;
    logic [CNT_W-1:0] e_out;
  } vec_t;

  typedef struct {
    logic req, rd; logic [33:0] cmd; logic [DQ_W-1:0] wd;
  } txn_t;

  // Random traffic checked against rules, not a cycle model: tag order is a
  // queue, priority is "the requester not granted last", issue spacing and
  // busy blocking are checked as forbidden windows.
  task automatic run_random(input int ncyc);
    int q[$];
    bit rr_b = 0, prev_valid = 0;
    int pm_left = 0, wait_a = 0, wait_b = 0;
    txn_t pa = '{default: '0};
    txn_t pb = '{default: '0};
    logic rdv_drv = 0;
    logic [DQ_W-1:0] rd_drv = '0;
    logic [3:0] pm_drv = '0;
    for (int c = 0; c < ncyc; c++) begin
      bit a_el, b_el, ga, gb;
      int id;
      @(negedge clk);
      a_el = pa.req && (!pa.rd || q.size() < TAG_DEPTH);
      b_el = pb.req && (!pb.rd || q.size() < TAG_DEPTH);
      ga = bus.a_gnt;
      gb = bus.b_gnt;
      chk("rnd_valid_vs_gnt", bus.pkg_valid, ga | gb);
      chk("rnd_double_gnt", ga & gb, 0);
      if (pm_drv != 0 || prev_valid) chk("rnd_issue_window", bus.pkg_valid, 0);
      if (ga) begin
        chk("rnd_a_eligible", a_el, 1);
        chk("rnd_a_cmd", bus.pkg_command, pa.cmd);
        chk("rnd_a_wdata", bus.pkg_write_data, pa.rd ? '0 : pa.wd);
        if (b_el) chk("rnd_rr_a", rr_b, 0);
      end
      if (gb) begin
        chk("rnd_b_eligible", b_el, 1);
        chk("rnd_b_cmd", bus.pkg_command, pb.cmd);
        chk("rnd_b_wdata", bus.pkg_write_data, pb.rd ? '0 : pb.wd);
        if (a_el) chk("rnd_rr_b", rr_b, 1);
      end
      if (rdv_drv) begin
        id = q.pop_front();
        chk("rnd_a_rvalid", bus.a_rvalid, id == 0);
        chk("rnd_b_rvalid", bus.b_rvalid, id == 1);
        chk("rnd_rdata", bus.rdata, rd_drv);
      end else begin
        chk("rnd_no_rvalid", bus.a_rvalid | bus.b_rvalid, 0);
      end
      if (ga) begin
        if (pa.rd) q.push_back(0);
        rr_b = 1; pa.req = 0; wait_a = 0;
      end else if (a_el) wait_a++;
      if (gb) begin
        if (pb.rd) q.push_back(1);
        rr_b = 0; pb.req = 0; wait_b = 0;
      end else if (b_el) wait_b++;
      chk("rnd_rd_outstanding", bus.rd_outstanding, q.size());
      chk("rnd_wait_bound", (wait_a > 64) || (wait_b > 64), 0);
      prev_valid = bus.pkg_valid;

      if (!pa.req && $urandom_range(0, 2) == 0)
        pa = '{1'b1, 1'($urandom_range(0, 1)), {2'($urandom_range(0, 3)), $urandom},
               {$urandom, $urandom, $urandom, $urandom}};
      if (!pb.req && $urandom_range(0, 2) == 0)
        pb = '{1'b1, 1'($urandom_range(0, 1)), {2'($urandom_range(0, 3)), $urandom},
               {$urandom, $urandom, $urandom, $urandom}};
      rdv_drv = (q.size() > 0) && ($urandom_range(0, 3) == 0);
      rd_drv  = {$urandom, $urandom, $urandom, $urandom};
      if (pm_left > 0) pm_left--;
      else if ($urandom_range(0, 11) == 0) pm_left = $urandom_range(1, 6);
      pm_drv = (pm_left > 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      bus.a_req = pa.req; bus.a_rd = pa.rd; bus.a_cmd = pa.cmd; bus.a_wdata = pa.wd;
      bus.b_req = pb.req; bus.b_rd = pb.rd; bus.b_cmd = pb.cmd; bus.b_wdata = pb.wd;
      bus.pkg_read_data_valid = rdv_drv;
      bus.pkg_read_data = rd_drv;
      bus.pkg_ba_cmd_pm = pm_drv;
    end
    chk("rnd_tag_err", bus.tag_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int n, ga, gb;
    tbl[0] = '{1, 0, CA, WA, 0, 0, CB, WB, 1, 0, CA, WA, 0};
    tbl[1] = '{0, 0, CA, WA, 1, 0, CB, WB, 0, 1, CB, WB, 0};
    tbl[2] = '{1, 0, CA, WA, 1, 0, CB, WB, 1, 0, CA, WA, 0};
    tbl[3] = '{1, 1, CA, WA, 0, 0, CB, WB, 1, 0, CA, '0, 1};
    tbl[4] = '{1, 0, CA, WA, 1, 1, CB, WB, 1, 0, CA, WA, 0};
    tbl[5] = '{0, 0, CA, WA, 1, 1, CB, WB, 0, 1, CB, '0, 1};
    tbl[6] = '{0, 0, CA, WA, 0, 0, CB, WB, 0, 0, '0, '0, 0};
    tbl[7] = '{1, 1, CA, WA, 1, 1, CB, WB, 1, 0, CA, '0, 1};

    do_reset();
    chk_all_zero("reset");

    foreach (tbl[i]) begin
      do_reset();
      bus.a_req = tbl[i].a_req; bus.a_rd = tbl[i].a_rd;
      bus.a_cmd = tbl[i].a_cmd; bus.a_wdata = tbl[i].a_wd;
      bus.b_req = tbl[i].b_req; bus.b_rd = tbl[i].b_rd;
      bus.b_cmd = tbl[i].b_cmd; bus.b_wdata = tbl[i].b_wd;
      @(negedge clk);
      chk($sformatf("vec%0d_a_gnt", i), bus.a_gnt, tbl[i].e_agnt);
      chk($sformatf("vec%0d_b_gnt", i), bus.b_gnt, tbl[i].e_bgnt);
      chk($sformatf("vec%0d_valid", i), bus.pkg_valid, tbl[i].e_agnt | tbl[i].e_bgnt);
      chk($sformatf("vec%0d_cmd", i), bus.pkg_command, tbl[i].e_cmd);
      chk($sformatf("vec%0d_wdata", i), bus.pkg_write_data, tbl[i].e_wd);
      chk($sformatf("vec%0d_outstanding", i), bus.rd_outstanding, tbl[i].e_out);
      @(negedge clk);
      chk($sformatf("vec%0d_valid_drop", i), bus.pkg_valid, 0);
      chk($sformatf("vec%0d_cmd_drop", i), bus.pkg_command, 0);
      idle_inputs();
    end

    // Round robin with both requesters writing continuously.
    do_reset();
    bus.a_req = 1; bus.a_cmd = CA; bus.a_wdata = WA;
    bus.b_req = 1; bus.b_cmd = CB; bus.b_wdata = WB;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_a_gnt", i), bus.a_gnt, (i % 4) == 0);
      chk($sformatf("rr%0d_b_gnt", i), bus.b_gnt, (i % 4) == 2);
      chk($sformatf("rr%0d_valid", i), bus.pkg_valid, (i % 2) == 0);
    end
    idle_inputs();

    // Read routing: A then B read rank 1, data returns in order.
    do_reset();
    bus.a_req = 1; bus.a_rd = 1; bus.a_cmd = {2'b01, 32'h0000_00A1};
    wait_gnt(0, "route_a_gnt");
    chk("route_a_cmd", bus.pkg_command, {2'b01, 32'h0000_00A1});
    bus.a_req = 0;
    bus.b_req = 1; bus.b_rd = 1; bus.b_cmd = {2'b01, 32'h0000_00B1};
    wait_gnt(1, "route_b_gnt");
    chk("route_b_cmd", bus.pkg_command, {2'b01, 32'h0000_00B1});
    bus.b_req = 0;
    bus.pkg_read_data_valid = 1; bus.pkg_read_data = {16{8'h11}};
    @(negedge clk);
    bus.pkg_read_data = {16{8'h22}};
    chk("route_a_rvalid", bus.a_rvalid, 1);
    chk("route_b_rvalid0", bus.b_rvalid, 0);
    chk("route_rdata_a", bus.rdata, {16{8'h11}});
    @(negedge clk);
    bus.pkg_read_data_valid = 0; bus.pkg_read_data = '0;
    chk("route_b_rvalid", bus.b_rvalid, 1);
    chk("route_a_rvalid0", bus.a_rvalid, 0);
    chk("route_rdata_b", bus.rdata, {16{8'h22}});
    @(negedge clk);
    chk("route_rvalid_drop", {bus.a_rvalid, bus.b_rvalid}, 0);
    chk("route_rdata_hold", bus.rdata, {16{8'h22}});
    chk("route_outstanding", bus.rd_outstanding, 0);
    idle_inputs();

    // FIFO full: reads blocked, writes pass, read resumes after one pop.
    do_reset();
    bus.a_req = 1; bus.a_rd = 1;
    for (int i = 0; i < TAG_DEPTH; i++) begin
      bus.a_cmd = 34'(i);
      wait_gnt(0, $sformatf("full_fill%0d", i));
    end
    bus.a_cmd = 34'h55;
    bus.b_req = 1; bus.b_rd = 0; bus.b_cmd = CB; bus.b_wdata = WB;
    ga = 0; gb = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) chk("full_outstanding", bus.rd_outstanding, TAG_DEPTH);
      ga += int'(bus.a_gnt);
      if (bus.b_gnt) begin gb++; bus.b_req = 0; end
    end
    chk("full_a_blocked", ga, 0);
    chk("full_b_write", gb, 1);
    bus.pkg_read_data_valid = 1; bus.pkg_read_data = {16{8'h5A}};
    @(negedge clk);
    bus.pkg_read_data_valid = 0;
    chk("full_pop_rvalid", bus.a_rvalid, 1);
    chk("full_a_early", bus.a_gnt, 0);
    @(negedge clk);
    chk("full_a_resume", bus.a_gnt, 1);
    chk("full_a_resume_cmd", bus.pkg_command, 34'h55);
    idle_inputs();

    // Rank switch spacing.
    do_reset();
    bus.a_req = 1; bus.a_cmd = {2'b00, 32'h1}; bus.a_wdata = WA;
    wait_gnt(0, "rank_first_gnt");
    bus.a_cmd = {2'b10, 32'h2};
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (bus.pkg_valid) break;
    end
    chk("rank_switch_spacing", n, EXP_SW);
    chk("rank_switch_cmd", bus.pkg_command, {2'b10, 32'h2});
    idle_inputs();

    // Busy window.
    do_reset();
    bus.pkg_ba_cmd_pm = 4'b0010;
    bus.a_req = 1; bus.a_cmd = CA; bus.a_wdata = WA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("busy%0d_no_valid", i), bus.pkg_valid, 0);
    end
    bus.pkg_ba_cmd_pm = 4'b0000;
    @(negedge clk);
    chk("busy_release_valid", bus.pkg_valid, 1);
    chk("busy_release_gnt", bus.a_gnt, 1);
    idle_inputs();

    // Reset mid-read, then orphan read data.
    do_reset();
    bus.a_req = 1; bus.a_rd = 1; bus.a_cmd = CA;
    wait_gnt(0, "rst_read_gnt");
    idle_inputs();
    @(negedge clk);
    chk("rst_pre_outstanding", bus.rd_outstanding, 1);
    power_on_rst = 1;
    @(negedge clk);
    chk_all_zero("rst_mid");
    power_on_rst = 0;
    bus.pkg_read_data_valid = 1; bus.pkg_read_data = {16{8'h77}};
    @(negedge clk);
    bus.pkg_read_data_valid = 0;
    chk("orphan_rvalid", {bus.a_rvalid, bus.b_rvalid}, 0);
    chk("orphan_tag_err", bus.tag_err, 1);
    chk("orphan_rdata", bus.rdata, 0);
    @(negedge clk);
    chk("orphan_tag_err_sticky", bus.tag_err, 1);

    do_reset();
    run_random(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
